// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on input and output.
// Define ALU_PIPE_FLAGS_EN to build the {N,V,C,Z} status flags; otherwise o_flags is tied to 0.
module alu_pipe #(
    parameter int DATA_W = 8,
    parameter int CODE_W = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [CODE_W-1:0] i_code,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_result,
    output logic [3:0]        o_flags,
    output logic              o_valid,
    input  logic              i_ready
);

    localparam logic [CODE_W-1:0] OP_ADD = CODE_W'(6'b100000);
    localparam logic [CODE_W-1:0] OP_SUB = CODE_W'(6'b100010);
    localparam logic [CODE_W-1:0] OP_AND = CODE_W'(6'b100100);
    localparam logic [CODE_W-1:0] OP_OR  = CODE_W'(6'b100101);
    localparam logic [CODE_W-1:0] OP_XOR = CODE_W'(6'b100110);
    localparam logic [CODE_W-1:0] OP_NOR = CODE_W'(6'b100111);
    localparam logic [CODE_W-1:0] OP_SRA = CODE_W'(6'b000011);
    localparam logic [CODE_W-1:0] OP_SRL = CODE_W'(6'b000010);
    localparam logic [CODE_W-1:0] OP_SLL = CODE_W'(6'b000000);
    localparam logic [CODE_W-1:0] OP_SLT = CODE_W'(6'b101010);

    // DATA_W always fits in DATA_W bits, so the shift-range test stays at operand width
    localparam logic [DATA_W-1:0] SHIFT_LIMIT = DATA_W'(DATA_W);

    logic              s1_valid;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic [CODE_W-1:0] s1_code;
    logic              s1_adv;
    logic              s2_adv;
    logic              shift_over;
    logic [DATA_W-1:0] result;

    assign s2_adv     = !o_valid || i_ready;
    assign s1_adv     = !s1_valid || s2_adv;
    assign o_ready    = s1_adv;
    assign shift_over = (s1_b >= SHIFT_LIMIT);

    always_comb begin
        result = '0;
        case (s1_code)
            OP_ADD:  result = s1_a + s1_b;
            OP_SUB:  result = s1_a - s1_b;
            OP_AND:  result = s1_a & s1_b;
            OP_OR:   result = s1_a | s1_b;
            OP_XOR:  result = s1_a ^ s1_b;
            OP_NOR:  result = ~(s1_a | s1_b);
            OP_SRA:  result = shift_over ? {DATA_W{s1_a[DATA_W-1]}}
                                         : $unsigned($signed(s1_a) >>> s1_b);
            OP_SRL:  result = shift_over ? '0 : (s1_a >> s1_b);
            OP_SLL:  result = shift_over ? '0 : (s1_a << s1_b);
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            default: result = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_code  <= '0;
        end else if (s1_adv) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_a    <= i_a;
                s1_b    <= i_b;
                s1_code <= i_code;
            end
        end
    end

    // Result only updates on a real beat so it holds its last value while o_valid is low
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid  <= 1'b0;
            o_result <= '0;
        end else if (s2_adv) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_result <= result;
            end
        end
    end

`ifdef ALU_PIPE_FLAGS_EN
    logic       carry;
    logic       ovf;
    logic [3:0] flags;

    always_comb begin
        carry = 1'b0;
        ovf   = 1'b0;
        if (s1_code == OP_ADD) begin
            // A modular sum below an operand means the add wrapped
            carry = (result < s1_a);
            ovf   = (s1_a[DATA_W-1] == s1_b[DATA_W-1]) && (result[DATA_W-1] != s1_a[DATA_W-1]);
        end else if (s1_code == OP_SUB) begin
            carry = (s1_a < s1_b);
            ovf   = (s1_a[DATA_W-1] != s1_b[DATA_W-1]) && (result[DATA_W-1] != s1_a[DATA_W-1]);
        end
        flags = {result[DATA_W-1], ovf, carry, (result == '0)};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_flags <= 4'b0000;
        end else if (s2_adv && s1_valid) begin
            o_flags <= flags;
        end
    end
`else
    assign o_flags = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors, backpressure, random handshakes, reset.
// Expected flags follow ALU_PIPE_FLAGS_EN (all zero when it is undefined).
module tb_alu_pipe;

`ifdef ALU_PIPE_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] code;
        logic [7:0] r;
        logic [3:0] f;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] code;
    logic       iv;
    logic       ordy;
    logic [7:0] res;
    logic [3:0] flg;
    logic       ov;
    logic       ir;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q [$];

    alu_pipe #(
        .DATA_W(8),
        .CODE_W(6)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_a     (a),
        .i_b     (b),
        .i_code  (code),
        .i_valid (iv),
        .o_ready (ordy),
        .o_result(res),
        .o_flags (flg),
        .o_valid (ov),
        .i_ready (ir)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic, returns {result, flags}
    function automatic logic [11:0] ref_alu(input logic [7:0] xa, input logic [7:0] xb,
                                            input logic [5:0] op);
        int ua = int'(xa);
        int ub = int'(xb);
        int sa = int'($signed(xa));
        int sb = int'($signed(xb));
        int r = 0;
        int c = 0;
        int v = 0;
        int full;
        logic [7:0] r8;
        logic [3:0] f;
        case (op)
            6'h20: begin
                full = sa + sb;
                r = (ua + ub) & 255;
                c = (ua + ub > 255) ? 1 : 0;
                v = (full > 127 || full < -128) ? 1 : 0;
            end
            6'h22: begin
                full = sa - sb;
                r = (ua - ub) & 255;
                c = (ua < ub) ? 1 : 0;
                v = (full > 127 || full < -128) ? 1 : 0;
            end
            6'h24: r = ua & ub;
            6'h25: r = ua | ub;
            6'h26: r = ua ^ ub;
            6'h27: r = (~(ua | ub)) & 255;
            6'h03: r = (ub >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> ub) & 255);
            6'h02: r = (ub >= 8) ? 0 : (ua >> ub);
            6'h00: r = (ub >= 8) ? 0 : ((ua << ub) & 255);
            6'h2A: r = (sa < sb) ? 1 : 0;
            default: r = 0;
        endcase
        r8 = 8'(r);
        f = {(r >= 128), (v != 0), (c != 0), (r == 0)};
        return {r8, FLAGS_ON ? f : 4'b0000};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        iv  = 1'b0;
        ir  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ov !== 1'b0 || res !== 8'h00 || flg !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b result=%h flags=%h, required 0/00/0",
                     ov, res, flg);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ordy !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b, required 1/0", ordy, ov);
        end
    endtask

    task automatic test_directed();
        vec_t vecs [11];
        logic [3:0] exp_f;
        vecs[0]  = '{8'h7F, 8'h01, 6'h20, 8'h80, 4'b1100};
        vecs[1]  = '{8'h00, 8'h01, 6'h22, 8'hFF, 4'b1010};
        vecs[2]  = '{8'hFF, 8'h01, 6'h2A, 8'h01, 4'b0000};
        vecs[3]  = '{8'h80, 8'h03, 6'h03, 8'hF0, 4'b1000};
        vecs[4]  = '{8'h80, 8'h03, 6'h02, 8'h10, 4'b0000};
        vecs[5]  = '{8'h01, 8'h09, 6'h00, 8'h00, 4'b0001};
        vecs[6]  = '{8'h55, 8'hAA, 6'h3F, 8'h00, 4'b0001};
        vecs[7]  = '{8'hFF, 8'h01, 6'h20, 8'h00, 4'b0011};
        vecs[8]  = '{8'h80, 8'h08, 6'h03, 8'hFF, 4'b1000};
        vecs[9]  = '{8'h0F, 8'hF0, 6'h27, 8'h00, 4'b0001};
        vecs[10] = '{8'h80, 8'h01, 6'h22, 8'h7F, 4'b0100};
        ir = 1'b1;
        foreach (vecs[i]) begin
            a    = vecs[i].a;
            b    = vecs[i].b;
            code = vecs[i].code;
            iv   = 1'b1;
            @(posedge clk);
            #1;
            iv = 1'b0;
            checks++;
            if (ov !== 1'b0) begin
                errors++;
                $display("FAIL directed_latency[%0d]: valid=%b one cycle after accept, required 0",
                         i, ov);
            end
            @(posedge clk);
            #1;
            exp_f = FLAGS_ON ? vecs[i].f : 4'b0000;
            checks++;
            if (ov !== 1'b1 || res !== vecs[i].r || flg !== exp_f) begin
                errors++;
                $display("FAIL directed[%0d]: valid=%b result=%h flags=%b, required 1/%h/%b",
                         i, ov, res, flg, vecs[i].r, exp_f);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [7:0] va [5];
        logic [7:0] vb [5];
        int sent = 0;
        int got = 0;
        int first = -1;
        int last = -1;
        logic [11:0] held = '0;
        logic [11:0] e;
        for (int i = 0; i < 5; i++) begin
            va[i] = 8'($urandom);
            vb[i] = 8'($urandom);
        end
        code = 6'h20;
        ir   = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            iv = (sent < 5);
            if (sent < 5) begin
                a = va[sent];
                b = vb[sent];
            end
            @(negedge clk);
            if (iv && ordy) begin
                exp_q.push_back(ref_alu(a, b, code));
                sent++;
            end
            if (cyc == 3) held = {res, flg};
            @(posedge clk);
            #1;
        end
        checks++;
        if (sent != 2 || ordy !== 1'b0) begin
            errors++;
            $display("FAIL bp_fill: accepted=%0d ready=%b, required 2/0", sent, ordy);
        end
        checks++;
        if (ov !== 1'b1 || {res, flg} !== held || {res, flg} !== exp_q[0]) begin
            errors++;
            $display("FAIL bp_hold: valid=%b out=%h earlier=%h, required 1/%h",
                     ov, {res, flg}, held, exp_q[0]);
        end
        ir = 1'b1;
        for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
            iv = (sent < 5);
            if (sent < 5) begin
                a = va[sent];
                b = vb[sent];
            end
            @(negedge clk);
            if (ov && ir) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: result=%h with nothing outstanding, required none", res);
                end else begin
                    e = exp_q.pop_front();
                    if ({res, flg} !== e) begin
                        errors++;
                        $display("FAIL bp_data[%0d]: out=%h, required %h", got, {res, flg}, e);
                    end
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (iv && ordy) begin
                exp_q.push_back(ref_alu(a, b, code));
                sent++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (got != 5 || last - first != 4) begin
            errors++;
            $display("FAIL bp_drain: delivered=%0d span=%0d cycles, required 5/4", got, last - first);
        end
        iv = 1'b0;
    endtask

    task automatic test_random();
        logic [5:0] ops [10];
        int sent = 0;
        int got = 0;
        bit have = 1'b0;
        bit stall = 1'b0;
        logic [12:0] held = '0;
        logic [11:0] e;
        ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02, 6'h00, 6'h2A};
        exp_q.delete();
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            if (!have && sent < 1000) begin
                a    = 8'($urandom);
                b    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
                code = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
                have = 1'b1;
            end
            iv = have && ($urandom_range(0, 3) != 0);
            ir = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (stall) begin
                checks++;
                if ({ov, res, flg} !== held) begin
                    errors++;
                    $display("FAIL rand_hold: out=%h, required stable %h", {ov, res, flg}, held);
                end
            end
            stall = ov && !ir;
            held  = {ov, res, flg};
            if (ov && ir) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: result=%h with nothing outstanding, required none", res);
                end else begin
                    e = exp_q.pop_front();
                    if ({res, flg} !== e) begin
                        errors++;
                        $display("FAIL rand_data[%0d]: out=%h, required %h", got, {res, flg}, e);
                    end
                end
                got++;
            end
            if (iv && ordy) begin
                exp_q.push_back(ref_alu(a, b, code));
                sent++;
                have = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        iv = 1'b0;
        checks++;
        if (got != 1000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_count: delivered=%0d outstanding=%0d, required 1000/0",
                     got, exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        logic [11:0] e;
        ir = 1'b1;
        iv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ir   = 1'b0;
        code = 6'h26;
        a    = 8'h12;
        b    = 8'h34;
        iv   = 1'b1;
        @(posedge clk);
        #1;
        a = 8'h56;
        b = 8'h78;
        @(posedge clk);
        #1;
        iv = 1'b0;
        checks++;
        if (ov !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: valid=%b before reset, required 1", ov);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ov !== 1'b0 || res !== 8'h00 || flg !== 4'h0) begin
            errors++;
            $display("FAIL rst_async: valid=%b result=%h flags=%h, required 0/00/0", ov, res, flg);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ir  = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ordy !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready: ready=%b after release, required 1", ordy);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ov !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale[%0d]: valid=%b result=%h, required valid 0", i, ov, res);
            end
        end
        @(posedge clk);
        #1;
        a    = 8'hA5;
        b    = 8'h0F;
        code = 6'h24;
        iv   = 1'b1;
        @(posedge clk);
        #1;
        iv = 1'b0;
        @(posedge clk);
        #1;
        e = ref_alu(8'hA5, 8'h0F, 6'h24);
        checks++;
        if (ov !== 1'b1 || {res, flg} !== e) begin
            errors++;
            $display("FAIL rst_next: valid=%b out=%h, required 1/%h", ov, {res, flg}, e);
        end
    endtask

    initial begin
        rst  = 1'b1;
        iv   = 1'b0;
        ir   = 1'b1;
        a    = '0;
        b    = '0;
        code = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, two-stage pipelined successor to the TP1 combinational ALU. The datapath width is generic and the result is registered. Valid/ready handshakes on both the input and output sides allow backpressure. Adds the SLL and SLT operations and optional status flags. It sits between the operand/opcode source (UART/switch front-end) and the result consumer.

Parameters:
DATA_W, 8, operand and result width in bits (>=4)
CODE_W, 6, opcode width; opcode values below are 6-bit MIPS funct codes, zero-extended if CODE_W>6

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous reset, active-high
i_a  in  DATA_W  operand a, signed
i_b  in  DATA_W  operand b, signed
i_code  in  CODE_W  operation select
i_valid  in  1  input beat valid
o_ready  out  1  block can accept an input beat this cycle
o_result  out  DATA_W  result
o_flags  out  4  {N, V, C, Z} status of o_result
o_valid  out  1  o_result/o_flags valid
i_ready  in  1  consumer accepts output this cycle

Behaviour:
- Reset is asynchronous and active-high on i_reset, single clock i_clk. On reset: o_valid=0, o_result=0, o_flags=0, both stage valid bits=0. o_ready returns 1 on the first clock after release.
- Stage 1 (S1) registers a, b and code when an input beat is accepted (i_valid && o_ready).
- Stage 2 (S2) computes the result and flags from the S1 registers and registers them into the outputs.
- Latency: result appears on o_valid exactly 2 cycles after acceptance if not stalled. Throughput is 1 beat/cycle.
- Advance rules:
  - s2_adv = !o_valid || i_ready
  - s1_adv = !s1_valid || s2_adv
  - o_ready = s1_adv (combinational)
- Output holding: o_result, o_flags and o_valid hold stable while o_valid && !i_ready.
- No loss or duplication: a beat is never lost or duplicated under any i_valid/i_ready pattern. Simultaneous accept in S1 and drain from S2 in the same cycle is legal.
- Operations (code : result), all arithmetic modulo 2^DATA_W:
  - 100000 ADD: a+b
  - 100010 SUB: a-b
  - 100100 AND: a&b
  - 100101 OR: a|b
  - 100110 XOR: a^b
  - 100111 NOR: ~(a|b)
  - 000011 SRA: arithmetic a>>>b
  - 000010 SRL: logical a>>b
  - 000000 SLL: a<<b
  - 101010 SLT: 1 if signed a<signed b, else 0
  - any other code: 0
- Shift rules: the shift amount is b treated as unsigned. If the amount is >= DATA_W, SRL and SLL give 0 and SRA gives all copies of a[MSB].
- Flags (when enabled):
  - Z = (result==0)
  - N = result[DATA_W-1]
  - C: ADD gives the unsigned carry-out; SUB gives the borrow (unsigned a<b); 0 for all other operations.
  - V: signed overflow for ADD/SUB; 0 for all other operations.
- Reset mid-operation: in-flight beats are discarded and never presented.
- While o_valid=0, o_result and o_flags hold their last values. The consumer must ignore them.

Optional Feature:
ALU_PIPE_FLAGS_EN
- Defined: the flag logic is built, and o_flags carries {N,V,C,Z} registered alongside o_result in S2.
- Undefined: no flag logic is synthesised and o_flags is tied to 4'b0000. The port list is unchanged.

Test Plan:
All cases use DATA_W=8 with ALU_PIPE_FLAGS_EN defined unless stated.
- ADD a=0x7F b=0x01, i_ready=1 -> o_result=0x80, flags N=1 V=1 C=0 Z=0, o_valid exactly 2 cycles after accept.
- SUB a=0x00 b=0x01 -> 0xFF, N=1 C=1 V=0; SLT a=0xFF(-1) b=0x01 -> 0x01; SRA a=0x80 b=3 -> 0xF0; SRL a=0x80 b=3 -> 0x10; SLL a=0x01 b=9 -> 0x00.
- Unknown code 0x3F with a=0x55 b=0xAA -> o_result=0x00, Z=1.
- Backpressure: stream 5 back-to-back ADDs with i_ready held 0 from cycle 2 -> o_ready drops after 2 beats are held, o_result stays stable. Releasing i_ready delivers all 5 results in order with no gaps or duplicates.
- Random i_valid/i_ready toggling, 1000 beats -> scoreboard matches a reference model in order, no loss.
- Assert i_reset with 2 beats in flight -> o_valid=0 asynchronously. After release, o_ready=1 and no stale result ever appears. Rebuild without the macro -> o_flags stays 0 throughout.
